neuron_backprop: RTL and testbench
==================================

Name: neuron_backprop

Overview:
Backward-pass counterpart of the forward neuron, used for on-chip training. Accepts one upstream error term per neuron together with the saved pre-activation, input vector and weight vector.
- Applies the ReLU derivative to form the local delta.
- Streams one result per weight index over a valid/ready handshake: the weight gradient and the error contribution propagated to the previous layer.
- Sits between the layer's error source and the weight-update / previous-layer accumulation logic.

Parameters:
NUM_WEIGHTS, 4, number of inputs/weights of the neuron (>=1)
WIDTH, 32, data word width, signed two's complement fixed point
FRAC_BITS, 16, fractional bits (Q16.16 at defaults)
IDX_W, $clog2(NUM_WEIGHTS) min 1, width of the index output

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start_valid  in  1  job request valid
start_ready  out  1  high only in IDLE
delta_in  in  WIDTH  upstream error term dL/da
z_in  in  WIDTH  saved pre-activation (forward sum plus bias)
in_vec  in  NUM_WEIGHTS*WIDTH  forward inputs, element i at [i*WIDTH +: WIDTH]
weight_vec  in  NUM_WEIGHTS*WIDTH  weights, same packing
grad_valid  out  1  grad_idx/grad_w/delta_prev valid
grad_ready  in  1  downstream accepts current element
grad_idx  out  IDX_W  weight index of current element
grad_w  out  WIDTH  dL/dw[i] = delta_local*in[i]
delta_prev  out  WIDTH  delta_local*w[i], error sent to input i
bias_grad  out  WIDTH  delta_local, held stable from SCALE until next job accept
done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset values: all outputs 0, except start_ready=1 (IDLE). State=IDLE.
- Reset mid-job aborts immediately. Nothing further is emitted, no done pulse.
- IDLE:
  - On start_valid&&start_ready, register delta_in, z_in, in_vec and weight_vec.
  - Inputs may change after acceptance.
  - Go to SCALE.
- SCALE (1 cycle):
  - delta_local = (z > 0) ? delta : 0. z==0 is treated as derivative 0.
  - Register delta_local and drive it on bias_grad.
  - Clear idx. Go to EMIT.
- EMIT:
  - grad_valid=1. grad_idx=idx. grad_w and delta_prev are registered products for idx.
  - Outputs stay stable while grad_valid && !grad_ready.
  - On handshake: if idx==NUM_WEIGHTS-1 go to DONE, else idx+1 and next element valid the following cycle.
  - Throughput is 1 element/cycle under continuous ready.
- DONE (1 cycle): done=1, grad_valid=0. Go to IDLE.
- Latency: accept at cycle 0, SCALE at cycle 1, first grad_valid at cycle 2, done at (last handshake cycle)+1.
- Arithmetic:
  - Full 2*WIDTH signed product. Result = product >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - Saturate to [0x7FFFFFFF, 0x80000000] (max/min signed WIDTH) when the shifted value overflows WIDTH.
  - Saturation applies independently to grad_w and delta_prev.
- Products are computed for the index being presented. Registered outputs load on the transition into EMIT and on each accepted handshake that is not the last.
- start_valid is ignored outside IDLE. A new job is never accepted in the DONE cycle.
- grad_ready high outside EMIT has no effect.
- NUM_WEIGHTS=1: exactly one element, then DONE.

Decomposition:
- Shared package nn_pkg holds:
  - WIDTH and FRAC_BITS defaults
  - the fixed-point saturating-multiply function (used by both forward and backward blocks)
  - the state enum {IDLE, SCALE, EMIT, DONE}
- One natural sub-module, fxp_mul_sat: signed WIDTH x WIDTH -> WIDTH shifted, saturated, combinational.
  - Two instances: grad_w path and delta_prev path.

Test Plan:
- Basic, NUM_WEIGHTS=4, grad_ready=1:
  - Stimulus: delta=0x00010000 (1.0), z=0x00020000, in[0]=0x00008000 (0.5), w[0]=0xFFFE0000 (-2.0).
  - Response: idx0 grad_w=0x00008000, delta_prev=0xFFFE0000, bias_grad=0x00010000. First grad_valid at cycle 2. done at cycle 6.
- ReLU gating:
  - Stimulus: z=0xFFFF0000 (-1.0), and separately z=0. Any delta/in/w.
  - Response: bias_grad=0. All 4 grad_w=0 and delta_prev=0. done still pulses.
- Backpressure:
  - Stimulus: grad_ready held low 3 cycles at idx1, random toggling elsewhere.
  - Response: grad_idx/grad_w/delta_prev stable while stalled. Indices 0..3 each accepted exactly once, in order.
- Saturation:
  - Stimulus: delta=0x7FFF0000, in[0]=0x00020000, w[0]=0xFFFE0000, z>0.
  - Response: grad_w=0x7FFFFFFF, delta_prev=0x80000000.
- Reset and handshake edges:
  - Stimulus: rst asserted while idx=2.
  - Response: next cycle grad_valid=0, start_ready=1, all outputs 0, no done.
  - Stimulus: start_valid held high through the job.
  - Response: second job accepted only after DONE, once back in IDLE.
- NUM_WEIGHTS=1 build:
  - Response: single element with grad_idx=0, then done.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the forward and backward neuron blocks.
//   - NN_WIDTH / NN_FRAC_BITS: default signed fixed-point format (Q16.16)
//   - state_t: sequencing states of the backward-pass neuron
//   - fxp_mul_sat: saturating fixed-point multiply at the default format
package nn_pkg;

  localparam int NN_WIDTH     = 32;
  localparam int NN_FRAC_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Full-width signed product, arithmetic shift right by the fraction bits
  // (truncation toward -inf), then clamp into the signed NN_WIDTH range.
  function automatic logic signed [NN_WIDTH-1:0] fxp_mul_sat(
    input logic signed [NN_WIDTH-1:0] a,
    input logic signed [NN_WIDTH-1:0] b
  );
    logic signed [2*NN_WIDTH-1:0] prod;
    logic signed [2*NN_WIDTH-1:0] shifted;
    prod    = a * b;
    shifted = prod >>> NN_FRAC_BITS;
    // In range exactly when every bit above the result's sign bit copies it.
    if ((&shifted[2*NN_WIDTH-1:NN_WIDTH-1]) || !(|shifted[2*NN_WIDTH-1:NN_WIDTH-1]))
      return shifted[NN_WIDTH-1:0];
    else if (shifted[2*NN_WIDTH-1])
      return {1'b1, {(NN_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(NN_WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// fxp_mul_sat: combinational signed fixed-point multiply with saturation.
//   a, b : signed WIDTH-bit operands with FRAC_BITS fractional bits
//   y    : (a*b) >>> FRAC_BITS, clamped to [min, max] of signed WIDTH
module fxp_mul_sat
  import nn_pkg::*;
#(
  parameter int WIDTH     = NN_WIDTH,
  parameter int FRAC_BITS = NN_FRAC_BITS
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;
  logic                      fits;

  assign prod    = a * b;
  assign shifted = prod >>> FRAC_BITS;
  // The result fits when the discarded upper bits all equal its sign bit.
  assign fits    = (&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]);

  always_comb begin
    y = shifted[WIDTH-1:0];
    if (!fits)
      y = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/neuron_backprop.sv
// neuron_backprop: backward pass of one ReLU neuron.
//   Accepts an upstream error (delta_in) plus the saved pre-activation,
//   inputs and weights, gates the error with the ReLU derivative and streams
//   one (grad_w, delta_prev) pair per weight index.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_valid/start_ready  job request; ready only while idle
//   delta_in, z_in           upstream error and saved pre-activation
//   in_vec, weight_vec       packed vectors, element i at [i*WIDTH +: WIDTH]
//   grad_valid/grad_ready    output stream handshake
//   grad_idx, grad_w         weight index and dL/dw[i] = delta_local*in[i]
//   delta_prev               delta_local*w[i], error for input i
//   bias_grad                delta_local, stable from SCALE to next accept
//   done                     one-cycle pulse after the last element
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. While valid is high and ready low, the producer holds every
// payload signal stable; valid never drops without a transfer (except reset).
module neuron_backprop
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHTS = 4,
  parameter int WIDTH       = NN_WIDTH,
  parameter int FRAC_BITS   = NN_FRAC_BITS,
  parameter int IDX_W       = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [WIDTH-1:0]           delta_in,
  input  logic [WIDTH-1:0]           z_in,
  input  logic [NUM_WEIGHTS*WIDTH-1:0] in_vec,
  input  logic [NUM_WEIGHTS*WIDTH-1:0] weight_vec,
  output logic                       grad_valid,
  input  logic                       grad_ready,
  output logic [IDX_W-1:0]           grad_idx,
  output logic [WIDTH-1:0]           grad_w,
  output logic [WIDTH-1:0]           delta_prev,
  output logic [WIDTH-1:0]           bias_grad,
  output logic                       done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS - 1);

  state_t                  state;
  logic signed [WIDTH-1:0] delta_r;
  logic signed [WIDTH-1:0] z_r;
  logic signed [WIDTH-1:0] in_r [NUM_WEIGHTS];
  logic signed [WIDTH-1:0] w_r  [NUM_WEIGHTS];
  logic [IDX_W-1:0]        idx;

  logic signed [WIDTH-1:0] delta_local;
  logic [IDX_W-1:0]        sel_idx;
  logic signed [WIDTH-1:0] mul_a;
  logic signed [WIDTH-1:0] mul_in;
  logic signed [WIDTH-1:0] mul_w;
  logic signed [WIDTH-1:0] prod_in;
  logic signed [WIDTH-1:0] prod_w;
  logic                    handshake;

  // ReLU derivative: strictly positive z passes delta, z <= 0 blocks it.
  assign delta_local = (!z_r[WIDTH-1] && (|z_r)) ? delta_r : '0;

  // Products are prepared for the element that will be presented next:
  // index 0 while in SCALE, idx+1 while in EMIT. In SCALE bias_grad is not
  // loaded yet, so the freshly gated delta feeds the multipliers directly.
  assign sel_idx   = (state == EMIT) ? idx + 1'b1 : '0;
  assign mul_a     = (state == SCALE) ? delta_local : $signed(bias_grad);
  assign mul_in    = in_r[sel_idx];
  assign mul_w     = w_r[sel_idx];
  assign handshake = grad_valid && grad_ready;
  assign grad_idx  = idx;

  fxp_mul_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_grad (
    .a (mul_a),
    .b (mul_in),
    .y (prod_in)
  );

  fxp_mul_sat #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul_prev (
    .a (mul_a),
    .b (mul_w),
    .y (prod_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      grad_valid  <= 1'b0;
      done        <= 1'b0;
      idx         <= '0;
      grad_w      <= '0;
      delta_prev  <= '0;
      bias_grad   <= '0;
      delta_r     <= '0;
      z_r         <= '0;
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
        in_r[i] <= '0;
        w_r[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            delta_r     <= delta_in;
            z_r         <= z_in;
            for (int i = 0; i < NUM_WEIGHTS; i++) begin
              in_r[i] <= in_vec[i*WIDTH +: WIDTH];
              w_r[i]  <= weight_vec[i*WIDTH +: WIDTH];
            end
            start_ready <= 1'b0;
            state       <= SCALE;
          end
        end
        SCALE: begin
          bias_grad  <= delta_local;
          idx        <= '0;
          grad_w     <= prod_in;
          delta_prev <= prod_w;
          grad_valid <= 1'b1;
          state      <= EMIT;
        end
        EMIT: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
              grad_valid <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              idx        <= idx + 1'b1;
              grad_w     <= prod_in;
              delta_prev <= prod_w;
            end
          end
        end
        DONE: begin
          done        <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          grad_valid  <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_backprop.sv
// tb_neuron_backprop: self-checking bench for neuron_backprop.
// Drives directed and randomized jobs into a 4-weight instance and a
// 1-weight instance, and compares the streamed results with a plain
// arithmetic reference of the ReLU-gated fixed-point products.
module tb_neuron_backprop;

  localparam int W = 32;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (4 weights) ----------------
  logic           start_valid, start_ready;
  logic [W-1:0]   delta_in, z_in;
  logic [N*W-1:0] in_vec, weight_vec;
  logic           grad_valid, grad_ready;
  logic [1:0]     grad_idx;
  logic [W-1:0]   grad_w, delta_prev, bias_grad;
  logic           done;

  neuron_backprop #(.NUM_WEIGHTS(N), .WIDTH(W), .FRAC_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .delta_in(delta_in), .z_in(z_in),
    .in_vec(in_vec), .weight_vec(weight_vec),
    .grad_valid(grad_valid), .grad_ready(grad_ready),
    .grad_idx(grad_idx), .grad_w(grad_w), .delta_prev(delta_prev),
    .bias_grad(bias_grad), .done(done)
  );

  // ---------------- DUT (1 weight) ----------------
  logic         s1_valid, s1_ready;
  logic [W-1:0] d1_in, z1_in, in1_vec, w1_vec;
  logic         g1_valid, g1_ready;
  logic [0:0]   g1_idx;
  logic [W-1:0] g1_w, p1_prev, b1_grad;
  logic         done1;

  neuron_backprop #(.NUM_WEIGHTS(1), .WIDTH(W), .FRAC_BITS(16)) dut1 (
    .clk(clk), .rst(rst),
    .start_valid(s1_valid), .start_ready(s1_ready),
    .delta_in(d1_in), .z_in(z1_in),
    .in_vec(in1_vec), .weight_vec(w1_vec),
    .grad_valid(g1_valid), .grad_ready(g1_ready),
    .grad_idx(g1_idx), .grad_w(g1_w), .delta_prev(p1_prev),
    .bias_grad(b1_grad), .done(done1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];  // {grad_w, delta_prev} per index, in order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, s, lo, hi;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    s  = p >>> 16;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    if (s > hi) return 32'h7FFF_FFFF;
    if (s < lo) return 32'h8000_0000;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_relu(input logic [W-1:0] d, input logic [W-1:0] z);
    int sz;
    sz = $signed(z);
    return (sz > 0) ? d : '0;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      default: return W'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;  // about +/-4.0
    endcase
  endfunction

  // ---------------- driver ----------------
  // Entered and left on a negedge. mode 0: ready always high, 1: random ready.
  // stall_idx >= 0 holds ready low for three cycles at that index.
  task automatic run_job(input logic [W-1:0] d, input logic [W-1:0] z,
                         input logic [W-1:0] iv [N], input logic [W-1:0] wv [N],
                         input int mode, input bit hold, input int stall_idx);
    logic [W-1:0] dl;
    logic [2*W-1:0] e;
    int c0, n, stall_cnt;
    bit first_seen, stalled, done_seen, r;
    logic [1:0]   s_idx;
    logic [W-1:0] s_w, s_p;

    exp_q.delete();
    dl = ref_relu(d, z);
    for (int i = 0; i < N; i++) exp_q.push_back({ref_mul(dl, iv[i]), ref_mul(dl, wv[i])});

    delta_in = d;
    z_in     = z;
    for (int i = 0; i < N; i++) begin
      in_vec[i*W +: W]     = iv[i];
      weight_vec[i*W +: W] = wv[i];
    end
    start_valid = 1'b1;
    chk("start_ready_idle", start_ready, 1);
    c0 = cyc;
    @(negedge clk);
    if (!hold) start_valid = 1'b0;
    delta_in   = $urandom;
    z_in       = $urandom;
    in_vec     = {$urandom, $urandom, $urandom, $urandom};
    weight_vec = {$urandom, $urandom, $urandom, $urandom};

    n = 0; stall_cnt = 0; first_seen = 0; stalled = 0; done_seen = 0;
    s_idx = '0; s_w = '0; s_p = '0;
    for (int t = 0; t < 200 && !done_seen; t++) begin
      if (done) begin
        done_seen = 1;
        if (mode == 0 && stall_idx < 0) chk("done_latency", cyc - c0, 6);
        chk("elements_before_done", n, N);
        chk("valid_low_in_done", grad_valid, 0);
        chk("no_accept_in_done", start_ready, 0);
      end else begin
        chk("busy_not_ready", start_ready, 0);
        r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (grad_valid && n == stall_idx && stall_cnt < 3) begin
          r = 1'b0;
          stall_cnt++;
        end
        if (grad_valid) begin
          if (!first_seen) begin
            first_seen = 1;
            chk("first_valid_latency", cyc - c0, 2);
          end
          chk("bias_grad", bias_grad, dl);
          if (stalled) begin
            chk("stall_idx_stable", grad_idx, s_idx);
            chk("stall_w_stable", grad_w, s_w);
            chk("stall_prev_stable", delta_prev, s_p);
          end
          if (r) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("grad_idx", grad_idx, n);
            chk("grad_w", grad_w, e[2*W-1:W]);
            chk("delta_prev", delta_prev, e[W-1:0]);
            n++;
            stalled = 0;
          end else begin
            stalled = 1;
            s_idx = grad_idx; s_w = grad_w; s_p = delta_prev;
          end
        end
        grad_ready = r;
        @(negedge clk);
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    grad_ready = 1'b0;
  endtask

  task automatic rand_vecs(output logic [W-1:0] iv [N], output logic [W-1:0] wv [N]);
    for (int i = 0; i < N; i++) begin
      iv[i] = rnd_word();
      wv[i] = rnd_word();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] iv [N];
  logic [W-1:0] wv [N];
  bit reached;

  initial begin
    rst = 1'b1;
    start_valid = 0; grad_ready = 0; delta_in = '0; z_in = '0; in_vec = '0; weight_vec = '0;
    s1_valid = 0; g1_ready = 0; d1_in = '0; z1_in = '0; in1_vec = '0; w1_vec = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_start_ready", start_ready, 1);
    chk("rst_grad_valid", grad_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_grad_idx", grad_idx, 0);
    chk("rst_grad_w", grad_w, 0);
    chk("rst_delta_prev", delta_prev, 0);
    chk("rst_bias_grad", bias_grad, 0);

    // Basic directed job, continuous ready
    rand_vecs(iv, wv);
    iv[0] = 32'h0000_8000;
    wv[0] = 32'hFFFE_0000;
    run_job(32'h0001_0000, 32'h0002_0000, iv, wv, 0, 0, -1);
    @(negedge clk);

    // ReLU gating: negative and zero pre-activation
    rand_vecs(iv, wv);
    run_job(32'h0003_0000, 32'hFFFF_0000, iv, wv, 0, 0, -1);
    @(negedge clk);
    rand_vecs(iv, wv);
    run_job(32'h0003_0000, 32'h0000_0000, iv, wv, 0, 0, -1);
    @(negedge clk);

    // Backpressure: three stalled cycles at index 1, random ready elsewhere
    rand_vecs(iv, wv);
    run_job(rnd_word(), 32'h0000_0100, iv, wv, 1, 0, 1);
    @(negedge clk);

    // Saturation in both directions
    rand_vecs(iv, wv);
    iv[0] = 32'h0002_0000;
    wv[0] = 32'hFFFE_0000;
    run_job(32'h7FFF_0000, 32'h0001_0000, iv, wv, 0, 0, -1);
    @(negedge clk);

    // Randomized jobs with random ready
    for (int j = 0; j < 6; j++) begin
      rand_vecs(iv, wv);
      run_job(rnd_word(), rnd_word(), iv, wv, 1, 0, -1);
      @(negedge clk);
    end

    // start_valid held through a job: next accept only once back in idle
    rand_vecs(iv, wv);
    run_job(rnd_word(), 32'h0000_0001, iv, wv, 0, 1, -1);
    @(negedge clk);
    rand_vecs(iv, wv);
    run_job(rnd_word(), 32'h0004_0000, iv, wv, 1, 0, -1);
    @(negedge clk);

    // Reset while presenting index 2
    rand_vecs(iv, wv);
    delta_in = 32'h0001_0000; z_in = 32'h0001_0000;
    for (int i = 0; i < N; i++) begin
      in_vec[i*W +: W] = iv[i];
      weight_vec[i*W +: W] = wv[i];
    end
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    grad_ready = 1'b1;
    reached = 0;
    for (int t = 0; t < 20 && !reached; t++) begin
      if (grad_valid && grad_idx == 2'd2) reached = 1;
      else @(negedge clk);
    end
    chk("reached_idx2", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_grad_valid", grad_valid, 0);
    chk("abort_start_ready", start_ready, 1);
    chk("abort_grad_idx", grad_idx, 0);
    chk("abort_grad_w", grad_w, 0);
    chk("abort_delta_prev", delta_prev, 0);
    chk("abort_bias_grad", bias_grad, 0);
    chk("abort_done", done, 0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("quiet_after_abort", {done, grad_valid}, 0);
    end
    grad_ready = 1'b0;

    // Single-weight build: one element at index 0, then done
    begin
      logic [W-1:0] d, z, a, b, dl;
      int c0;
      bit seen;
      d = rnd_word(); z = 32'h0000_8000; a = rnd_word(); b = rnd_word();
      dl = ref_relu(d, z);
      d1_in = d; z1_in = z; in1_vec = a; w1_vec = b;
      chk("nw1_start_ready", s1_ready, 1);
      s1_valid = 1'b1;
      c0 = cyc;
      @(negedge clk);
      s1_valid = 1'b0;
      d1_in = $urandom; in1_vec = $urandom; w1_vec = $urandom;
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        if (g1_valid) seen = 1;
        else @(negedge clk);
      end
      chk("nw1_valid_seen", seen, 1);
      chk("nw1_latency", cyc - c0, 2);
      chk("nw1_idx", g1_idx, 0);
      chk("nw1_grad_w", g1_w, ref_mul(dl, a));
      chk("nw1_delta_prev", p1_prev, ref_mul(dl, b));
      chk("nw1_bias_grad", b1_grad, dl);
      g1_ready = 1'b1;
      @(negedge clk);
      g1_ready = 1'b0;
      chk("nw1_done", done1, 1);
      chk("nw1_valid_low", g1_valid, 0);
      @(negedge clk);
      chk("nw1_done_pulse", done1, 0);
      chk("nw1_idle", s1_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
